// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, flag indices and width for the ALU
package alu_pkg;

    localparam int WIDTH = 32;

    localparam logic [2:0] OP_SLA = 3'b000;
    localparam logic [2:0] OP_SRA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    localparam int FLG_V = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 2;

endpackage

// File: rtl/alu_mul.sv
// rtl/alu_mul.sv - combinational signed multiplier with low word and overflow
module alu_mul #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic             ovf
);

    logic signed [2*WIDTH-1:0] ax;
    logic signed [2*WIDTH-1:0] bx;
    logic signed [2*WIDTH-1:0] p;
    logic        [WIDTH:0]     top;

    // Operands are sign-extended explicitly so the product is the full signed result.
    assign ax  = {{WIDTH{a[WIDTH-1]}}, a};
    assign bx  = {{WIDTH{b[WIDTH-1]}}, b};
    assign p   = ax * bx;
    assign lo  = p[WIDTH-1:0];

    // The product fits in WIDTH signed bits only when the upper half and the low sign bit agree.
    assign top = p[2*WIDTH-1:WIDTH-1];
    assign ovf = !((&top) || !(|top));

endmodule

// File: rtl/alu_core.sv
// rtl/alu_core.sv - 32-bit signed ALU with registered result and V/Z/N flags
import alu_pkg::*;

module alu_core (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] c,
    output logic [2:0]       d
);

    logic [WIDTH-1:0] mul_lo;
    logic             mul_ovf;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res;
    logic             v;
    logic [2:0]       flags;

    alu_mul #(.WIDTH(WIDTH)) u_mul (
        .a   (a),
        .b   (b),
        .lo  (mul_lo),
        .ovf (mul_ovf)
    );

    assign sum  = a + b;
    assign diff = a - b;

    // Select the wrapped result and signed overflow for the current opcode.
    always_comb begin
        res = '0;
        v   = 1'b0;
        case (opcode)
            OP_SLA: begin
                res = {a[WIDTH-2:0], 1'b0};
                v   = a[WIDTH-1] ^ a[WIDTH-2];
            end
            OP_SRA: res = {a[WIDTH-1], a[WIDTH-1:1]};
            OP_ADD: begin
                res = sum;
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff;
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL: begin
                res = mul_lo;
                v   = mul_ovf;
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_NOT: res = ~a;
            default: begin
                res = '0;
                v   = 1'b0;
            end
        endcase
    end

    // Zero and negative always reflect the wrapped result.
    always_comb begin
        flags        = 3'b000;
        flags[FLG_V] = v;
        flags[FLG_Z] = (res == '0);
        flags[FLG_N] = res[WIDTH-1];
    end

    // Single output register stage; reset clears the in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c <= '0;
            d <= 3'b000;
        end else begin
            c <= res;
            d <= flags;
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - self-checking bench for alu_core
import alu_pkg::*;

module tb_alu_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  opcode;
    logic [31:0] c;
    logic [2:0]  d;

    int errors;
    int checks;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_c;
        logic [2:0]  exp_d;
        logic [2:0]  d_mask;
        bit          chk_c;
    } vec_t;

    vec_t vecs[12];

    alu_core dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .opcode (opcode),
        .c      (c),
        .d      (d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact signed arithmetic in 64 bits, overflow = out of 32-bit signed range.
    function automatic void model(input logic [2:0] op, input logic [31:0] ua, input logic [31:0] ub,
                                  output logic [31:0] mc, output logic [2:0] md);
        int     ia;
        int     ib;
        longint r;
        bit     arith;
        bit     v;
        ia    = ua;
        ib    = ub;
        arith = 1'b0;
        r     = 0;
        case (op)
            OP_SLA: begin r = longint'(ia) * 2; arith = 1'b1; end
            OP_SRA: r = longint'(ia) >>> 1;
            OP_ADD: begin r = longint'(ia) + longint'(ib); arith = 1'b1; end
            OP_SUB: begin r = longint'(ia) - longint'(ib); arith = 1'b1; end
            OP_MUL: begin r = longint'(ia) * longint'(ib); arith = 1'b1; end
            OP_AND: r = longint'(ia & ib);
            OP_OR:  r = longint'(ia | ib);
            default: r = longint'(~ia);
        endcase
        v  = arith && (r > 64'sd2147483647 || r < -64'sd2147483648);
        mc = r[31:0];
        md = {mc[31], (mc == 32'd0), v};
    endfunction

    task automatic apply(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        opcode = op;
        a      = va;
        b      = vb;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] mc;
    logic [2:0]  md;
    logic [31:0] specials[6];

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        a      = '0;
        b      = '0;
        opcode = OP_ADD;

        vecs[0]  = '{OP_SLA, 32'hC29B2CC1, 32'h0,        32'h85365982, 3'b100, 3'b111, 1'b1};
        vecs[1]  = '{OP_SLA, 32'h829B2CC1, 32'h0,        32'h05365982, 3'b001, 3'b111, 1'b1};
        vecs[2]  = '{OP_ADD, 32'h80000000, 32'h80000000, 32'h00000000, 3'b011, 3'b111, 1'b1};
        vecs[3]  = '{OP_ADD, 32'h7FFFFFFF, 32'h1,        32'h80000000, 3'b101, 3'b111, 1'b1};
        vecs[4]  = '{OP_SUB, 32'h529B2CC1, 32'h529B2CC1, 32'h00000000, 3'b010, 3'b111, 1'b1};
        vecs[5]  = '{OP_SUB, 32'h82000000, 32'h3FFFFFFF, 32'h42000001, 3'b001, 3'b111, 1'b1};
        vecs[6]  = '{OP_MUL, 32'h9,        32'hFFFFFFF3, 32'hFFFFFF8B, 3'b100, 3'b111, 1'b1};
        vecs[7]  = '{OP_MUL, 32'h529B2CC1, 32'h529B2CC1, 32'h0,        3'b001, 3'b001, 1'b0};
        vecs[8]  = '{OP_MUL, 32'h529B2CC1, 32'h0,        32'h00000000, 3'b010, 3'b111, 1'b1};
        vecs[9]  = '{OP_NOT, 32'hFFFFFFFF, 32'h0,        32'h00000000, 3'b010, 3'b111, 1'b1};
        vecs[10] = '{OP_AND, 32'hFFFFFFFF, 32'h0,        32'h00000000, 3'b010, 3'b111, 1'b1};
        vecs[11] = '{OP_OR,  32'hC29B2CC1, 32'hD2D23212, 32'hD2DB3ED3, 3'b100, 3'b111, 1'b1};

        specials[0] = 32'h00000000;
        specials[1] = 32'h00000001;
        specials[2] = 32'hFFFFFFFF;
        specials[3] = 32'h80000000;
        specials[4] = 32'h7FFFFFFF;
        specials[5] = 32'h40000000;

        // Reset state, including across a clock edge.
        #12;
        chk("reset_c", c, 32'h0);
        chk("reset_d", {29'd0, d}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            if (vecs[i].chk_c)
                chk($sformatf("vec%0d_c", i), c, vecs[i].exp_c);
            chk($sformatf("vec%0d_d", i), {29'd0, d & vecs[i].d_mask}, {29'd0, vecs[i].exp_d & vecs[i].d_mask});
        end

        // Reset mid-stream: asynchronous clear, held across an edge, then resume.
        apply(OP_ADD, 32'h7FFFFFFF, 32'h1);
        chk("pre_rst_c", c, 32'h80000000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_c", c, 32'h0);
        chk("async_rst_d", {29'd0, d}, 32'h0);
        @(posedge clk);
        #1;
        chk("held_rst_c", c, 32'h0);
        @(negedge clk);
        opcode = OP_SUB;
        a      = 32'h82000000;
        b      = 32'h3FFFFFFF;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_c", c, 32'h42000001);
        chk("post_rst_d", {29'd0, d}, 32'h1);

        // Randomized ops with corner-biased operands against the reference.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic [2:0]  rop;
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 4) == 0)
                rb = 32'($urandom_range(0, 65535)) - 32'd32768;
            apply(rop, ra, rb);
            model(rop, ra, rb, mc, md);
            chk($sformatf("rnd%0d_op%0d_c", i, rop), c, mc);
            chk($sformatf("rnd%0d_op%0d_d", i, rop), {29'd0, d}, {29'd0, md});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
